// File: rtl/axist_pkt_rr_arbiter.sv
// axist_pkt_rr_arbiter: packet-atomic round-robin arbiter from NUM_SRC AXI-ST sources onto one registered Avalon-ST sink.
module axist_pkt_rr_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int SRC_BITS    = 1,
  parameter int DATA_WIDTH  = 64,
  parameter int NO_OF_BYTES = 8,
  parameter int EMPTY_BITS  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_SRC*NO_OF_BYTES-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic                           avst_valid,
  input  logic                           avst_ready,
  output logic [DATA_WIDTH-1:0]          avst_data,
  output logic                           avst_sop,
  output logic                           avst_eop,
  output logic [EMPTY_BITS-1:0]          avst_empty,
  output logic [SRC_BITS-1:0]            avst_channel,
  output logic                           busy,
  output logic                           err_null_eop
);
  typedef enum logic {ARB, XFER} state_t;
  state_t state, state_nxt;
  logic [SRC_BITS-1:0] grant, ptr, pick;
  logic [2*NUM_SRC-1:0] rot;
  logic [NO_OF_BYTES-1:0] keep_g;
  logic [EMPTY_BITS:0] zeros;
  logic [EMPTY_BITS-1:0] empty_g;
  logic found, first, take, last_g;
  // requests rotated so bit 0 is the pointer's source; lowest set bit wins
  assign rot = {s_axis_tvalid, s_axis_tvalid} >> ptr;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        pick  = SRC_BITS'((int'(ptr) + i) % NUM_SRC);
      end
  end
  assign s_axis_tready = (state == XFER && (!avst_valid || avst_ready)) ? NUM_SRC'(1) << grant : '0;
  assign take   = |(s_axis_tready & s_axis_tvalid);
  assign last_g = s_axis_tlast[grant];
  assign keep_g = s_axis_tkeep[grant*NO_OF_BYTES +: NO_OF_BYTES];
  always_comb begin
    zeros = '0;
    for (int i = 0; i < NO_OF_BYTES; i++) zeros = zeros + (EMPTY_BITS+1)'(!keep_g[i]);
  end
  assign empty_g = !last_g ? '0 : (keep_g == '0) ? EMPTY_BITS'(NO_OF_BYTES-1) : zeros[EMPTY_BITS-1:0];
  assign err_null_eop = take && last_g && keep_g == '0;
  assign busy = state == XFER;
  always_comb state_nxt = state == ARB ? (found ? XFER : ARB) : (take && last_g ? ARB : XFER);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= ARB;
      grant        <= '0;
      ptr          <= '0;
      first        <= 1'b0;
      avst_valid   <= 1'b0;
      avst_data    <= '0;
      avst_sop     <= 1'b0;
      avst_eop     <= 1'b0;
      avst_empty   <= '0;
      avst_channel <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && found) begin
        grant <= pick;
        ptr   <= SRC_BITS'((int'(pick) + 1) % NUM_SRC);
        first <= 1'b1;
      end
      if (take) begin
        avst_valid   <= 1'b1;
        avst_data    <= s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
        avst_sop     <= first;
        avst_eop     <= last_g;
        avst_empty   <= empty_g;
        avst_channel <= grant;
        first        <= 1'b0;
      end else if (avst_ready) avst_valid <= 1'b0;
    end
endmodule
